// File: rtl/system_loader.sv
// System loader: streams IRAM/DRAM images in, starts the CPU and times the run,
// and streams DRAM contents back out on a valid/ready response channel.
module system_loader #(
  parameter int unsigned W_I     = 16,
  parameter int unsigned W_D     = 8,
  parameter int unsigned I_DEPTH = 256,
  parameter int unsigned D_DEPTH = 256,
  parameter int unsigned W_S     = 16,
  localparam int unsigned AI     = $clog2(I_DEPTH),
  localparam int unsigned AD     = $clog2(D_DEPTH)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [W_S-1:0] s_data,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [W_S-1:0] m_data,
  output logic           m_last,
  output logic           iram_write,
  output logic [AI-1:0]  iram_addr,
  output logic [W_I-1:0] iram_din,
  output logic           dram_write,
  output logic [AD-1:0]  dram_addr,
  output logic [W_D-1:0] dram_din,
  input  logic [W_D-1:0] dram_dout,
  output logic           cpu_start,
  input  logic           cpu_idle,
  output logic           busy,
  output logic           err
);

  localparam int unsigned CW = W_S - 2;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD_I    = 3'd1;
  localparam logic [2:0] S_LOAD_D    = 3'd2;
  localparam logic [2:0] S_RUN_START = 3'd3;
  localparam logic [2:0] S_RUN_WAIT  = 3'd4;
  localparam logic [2:0] S_RUN_RESP  = 3'd5;
  localparam logic [2:0] S_DUMP_RD   = 3'd6;
  localparam logic [2:0] S_DUMP_TX   = 3'd7;

  logic [2:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, len_q;
  logic [W_S-1:0] cyc_q, data_q;
  logic           tx_first_q, err_q;
  logic [1:0]     hdr_cmd;
  logic [CW-1:0]  hdr_len;
  logic           last_word, i_in_range, d_in_range, dump_last;

  assign hdr_cmd    = s_data[W_S-1 -: 2];
  assign hdr_len    = s_data[CW-1:0];
  assign last_word  = (cnt_q == len_q);
  assign i_in_range = (32'(cnt_q) < I_DEPTH);
  assign d_in_range = (32'(cnt_q) < D_DEPTH);
  assign dump_last  = last_word || (32'(cnt_q) == D_DEPTH - 1);

  // Both memories are addressed by the shared word counter.
  assign iram_addr = AI'(cnt_q);
  assign dram_addr = AD'(cnt_q);
  assign iram_din  = s_data[W_I-1:0];
  assign dram_din  = s_data[W_D-1:0];
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and per-state strobes
  always_comb begin
    state_d    = state_q;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    m_last     = 1'b0;
    m_data     = '0;
    iram_write = 1'b0;
    dram_write = 1'b0;
    cpu_start  = 1'b0;
    case (state_q)
      S_IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          case (hdr_cmd)
            2'b00:   state_d = S_LOAD_I;
            2'b01:   state_d = S_LOAD_D;
            2'b10:   state_d = S_RUN_START;
            default: state_d = S_DUMP_RD;
          endcase
        end
      end
      S_LOAD_I: begin
        s_ready = 1'b1;
        if (s_valid) begin
          iram_write = i_in_range;
          if (last_word) state_d = S_IDLE;
        end
      end
      S_LOAD_D: begin
        s_ready = 1'b1;
        if (s_valid) begin
          dram_write = d_in_range;
          if (last_word) state_d = S_IDLE;
        end
      end
      S_RUN_START: begin
        cpu_start = 1'b1;
        state_d   = S_RUN_WAIT;
      end
      S_RUN_WAIT: begin
        if (cpu_idle) state_d = S_RUN_RESP;
      end
      S_RUN_RESP: begin
        m_valid = 1'b1;
        m_last  = 1'b1;
        m_data  = cyc_q;
        if (m_ready) state_d = S_IDLE;
      end
      S_DUMP_RD: begin
        state_d = S_DUMP_TX;
      end
      S_DUMP_TX: begin
        m_valid = 1'b1;
        m_last  = dump_last;
        // First TX cycle forwards the RAM output so a word can leave every two cycles.
        m_data  = tx_first_q ? W_S'(dram_dout) : data_q;
        if (m_ready) state_d = dump_last ? S_IDLE : S_DUMP_RD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counters, captured read data and sticky overflow flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q      <= '0;
      len_q      <= '0;
      cyc_q      <= '0;
      data_q     <= '0;
      tx_first_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      tx_first_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (s_valid) begin
            cnt_q <= '0;
            len_q <= hdr_len;
            if (hdr_cmd == 2'b11 && 32'(hdr_len) >= D_DEPTH) err_q <= 1'b1;
          end
        end
        S_LOAD_I: begin
          if (s_valid) begin
            cnt_q <= cnt_q + CW'(1);
            if (!i_in_range) err_q <= 1'b1;
          end
        end
        S_LOAD_D: begin
          if (s_valid) begin
            cnt_q <= cnt_q + CW'(1);
            if (!d_in_range) err_q <= 1'b1;
          end
        end
        S_RUN_START: cyc_q <= '0;
        S_RUN_WAIT: begin
          if (cyc_q != '1) cyc_q <= cyc_q + W_S'(1);
        end
        S_DUMP_RD: tx_first_q <= 1'b1;
        S_DUMP_TX: begin
          if (tx_first_q) data_q <= W_S'(dram_dout);
          if (m_ready && !dump_last) cnt_q <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_system_loader.sv
// Randomized bench for system_loader against a queue/array reference of the
// loader's command rules, with behavioural IRAM/DRAM models attached.
module tb_system_loader;
  localparam int unsigned W_I = 16, W_D = 8, I_DEPTH = 256, D_DEPTH = 256, W_S = 16;
  localparam int unsigned AI = 8, AD = 8;

  logic           clk = 1'b0;
  logic           rstn;
  logic           s_valid, s_ready;
  logic [W_S-1:0] s_data;
  logic           m_valid, m_ready, m_last;
  logic [W_S-1:0] m_data;
  logic           iram_write, dram_write;
  logic [AI-1:0]  iram_addr;
  logic [W_I-1:0] iram_din;
  logic [AD-1:0]  dram_addr;
  logic [W_D-1:0] dram_din, dram_dout;
  logic           cpu_start, cpu_idle, busy, err;

  system_loader #(.W_I(W_I), .W_D(W_D), .I_DEPTH(I_DEPTH), .D_DEPTH(D_DEPTH), .W_S(W_S)) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .iram_write(iram_write), .iram_addr(iram_addr), .iram_din(iram_din),
    .dram_write(dram_write), .dram_addr(dram_addr), .dram_din(dram_din), .dram_dout(dram_dout),
    .cpu_start(cpu_start), .cpu_idle(cpu_idle), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Memory models seen by the DUT, plus write and start-pulse counters
  logic [W_I-1:0] iram_mem [I_DEPTH];
  logic [W_D-1:0] dram_mem [D_DEPTH];
  int iwr_cnt = 0, dwr_cnt = 0, n_starts = 0;
  always @(posedge clk) begin
    if (iram_write) begin iram_mem[iram_addr] <= iram_din; iwr_cnt <= iwr_cnt + 1; end
    if (dram_write) begin dram_mem[dram_addr] <= dram_din; dwr_cnt <= dwr_cnt + 1; end
    dram_dout <= dram_mem[dram_addr];
  end
  always @(negedge clk) if (cpu_start) n_starts <= n_starts + 1;

  // Reference state
  logic [W_I-1:0] ref_iram [I_DEPTH];
  logic [W_D-1:0] ref_dram [D_DEPTH];
  logic           ref_err;
  logic [W_S-1:0] pay_q[$];

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic do_load(input bit is_d, input int max_gap);
    int n, depth, i0, d0, gap, nwr;
    logic [W_S-1:0] w;
    bit exp_wr;
    n = pay_q.size();
    depth = is_d ? D_DEPTH : I_DEPTH;
    nwr = (n < depth) ? n : depth;
    i0 = iwr_cnt; d0 = dwr_cnt;
    step(); s_valid = 1'b1; s_data = {is_d ? 2'b01 : 2'b00, 14'(n - 1)};
    #1 chk("ld_hdr_ready", 32'(s_ready), 1);
    for (int i = 0; i < n; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) begin
        step(); #1;
        chk("ld_gap_nowr", 32'(iram_write | dram_write), 0);
      end
      w = pay_q[i];
      step(); s_valid = 1'b1; s_data = w; #1;
      exp_wr = (i < depth);
      chk("ld_ready", 32'(s_ready), 1);
      chk("ld_iram_wr", 32'(iram_write), 32'(exp_wr && !is_d));
      chk("ld_dram_wr", 32'(dram_write), 32'(exp_wr && is_d));
      if (exp_wr && is_d) begin
        chk("ld_dram_addr", 32'(dram_addr), i);
        chk("ld_dram_din", 32'(dram_din), 32'(w[7:0]));
        ref_dram[i] = w[7:0];
      end else if (exp_wr) begin
        chk("ld_iram_addr", 32'(iram_addr), i);
        chk("ld_iram_din", 32'(iram_din), 32'(w));
        ref_iram[i] = w;
      end else begin
        ref_err = 1'b1;
      end
    end
    step(); #1;
    chk("ld_done_busy", 32'(busy), 0);
    chk("ld_no_resp", 32'(m_valid), 0);
    chk("ld_err", 32'(err), 32'(ref_err));
    chk("ld_iwr_count", iwr_cnt - i0, is_d ? 0 : nwr);
    chk("ld_dwr_count", dwr_cnt - d0, is_d ? nwr : 0);
    pay_q.delete();
  endtask

  task automatic recv_word(input logic [W_S-1:0] ed, input bit el, input int stall,
                           input int exp_wait, input string tag);
    int waited, st;
    waited = 0;
    do begin step(); #1; waited++; end while (!m_valid && waited < 64);
    chk({tag, "_valid"}, 32'(m_valid), 1);
    if (!m_valid) return;
    if (exp_wait > 0) chk({tag, "_gap"}, waited, exp_wait);
    st = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
    for (int s = 0; s < st; s++) begin
      chk({tag, "_hold_valid"}, 32'(m_valid), 1);
      chk({tag, "_hold_data"}, 32'(m_data), 32'(ed));
      chk({tag, "_hold_last"}, 32'(m_last), 32'(el));
      step(); #1;
    end
    m_ready = 1'b1; #1;
    chk({tag, "_data"}, 32'(m_data), 32'(ed));
    chk({tag, "_last"}, 32'(m_last), 32'(el));
    chk({tag, "_sready"}, 32'(s_ready), 0);
  endtask

  task automatic do_run(input int k);
    int s0, i0, d0;
    s0 = n_starts; i0 = iwr_cnt; d0 = dwr_cnt;
    step(); s_valid = 1'b1; s_data = 16'h8000 | 16'($urandom_range(0, 16383)); cpu_idle = 1'b0;
    #1 chk("run_hdr_ready", 32'(s_ready), 1);
    step(); #1;
    chk("run_start", 32'(cpu_start), 1);
    chk("run_sready", 32'(s_ready), 0);
    if (k == 0) cpu_idle = 1'b1;
    for (int j = 1; j <= k; j++) begin
      step();
      if (j == k) cpu_idle = 1'b1;
      #1;
      chk("run_wait_start", 32'(cpu_start), 0);
      chk("run_wait_mvalid", 32'(m_valid), 0);
      chk("run_wait_busy", 32'(busy), 1);
    end
    // Cycles spent waiting: the idle flag is only seen from the cycle after the start pulse.
    recv_word((k == 0) ? 16'd1 : 16'(k), 1'b1, -1, 0, "run");
    cpu_idle = 1'b0;
    step(); #1;
    chk("run_done_busy", 32'(busy), 0);
    chk("run_start_pulses", n_starts - s0, 1);
    chk("run_no_writes", (iwr_cnt - i0) + (dwr_cnt - d0), 0);
    chk("run_err", 32'(err), 32'(ref_err));
  endtask

  task automatic do_dump(input int n, input int first_stall);
    int nw, i0, d0;
    nw = (n > int'(D_DEPTH)) ? D_DEPTH : n;
    i0 = iwr_cnt; d0 = dwr_cnt;
    if (n > int'(D_DEPTH)) ref_err = 1'b1;
    step(); s_valid = 1'b1; s_data = {2'b11, 14'(n - 1)};
    #1 chk("dump_hdr_ready", 32'(s_ready), 1);
    for (int i = 0; i < nw; i++)
      recv_word({8'h00, ref_dram[i]}, i == nw - 1, (i == 0) ? first_stall : -1, 2, "dump");
    step(); #1;
    chk("dump_done_busy", 32'(busy), 0);
    chk("dump_err", 32'(err), 32'(ref_err));
    chk("dump_no_writes", (iwr_cnt - i0) + (dwr_cnt - d0), 0);
  endtask

  task automatic chk_mem();
    int bad_i, bad_d;
    bad_i = 0; bad_d = 0;
    for (int i = 0; i < int'(I_DEPTH); i++) if (iram_mem[i] !== ref_iram[i]) bad_i++;
    for (int i = 0; i < int'(D_DEPTH); i++) if (dram_mem[i] !== ref_dram[i]) bad_d++;
    chk("iram_content", bad_i, 0);
    chk("dram_content", bad_d, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_valid"}, 32'(m_valid), 0);
    chk({tag, "_m_last"}, 32'(m_last), 0);
    chk({tag, "_m_data"}, 32'(m_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_cpu_start"}, 32'(cpu_start), 0);
    chk({tag, "_wr"}, 32'(iram_write | dram_write), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, n;
    rstn = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; cpu_idle = 1'b0;
    ref_err = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk_reset_outputs("por");
    step(); rstn = 1'b1;

    // Three IRAM words back to back
    pay_q = {16'h1234, 16'h0001, 16'h0000};
    do_load(1'b0, 0);

    // Full-depth loads plus one overflow word each
    for (int i = 0; i < 257; i++) pay_q.push_back(16'($urandom));
    do_load(1'b1, 0);
    for (int i = 0; i < 257; i++) pay_q.push_back(16'($urandom));
    do_load(1'b0, 0);
    chk_mem();

    // Two DRAM words then dump them, first word held for five cycles
    pay_q = {16'h00AA, 16'h0055};
    do_load(1'b1, 0);
    do_dump(2, 5);

    do_run(10);
    do_run(0);
    do_dump(300, 0);

    for (int it = 0; it < 16; it++) begin
      op = int'($urandom_range(0, 3));
      case (op)
        0, 1: begin
          n = int'($urandom_range(1, 24));
          for (int i = 0; i < n; i++) pay_q.push_back(16'($urandom));
          do_load(op == 1, 2);
        end
        2: do_run(int'($urandom_range(0, 12)));
        default: do_dump(int'($urandom_range(1, 12)), -1);
      endcase
      repeat ($urandom_range(0, 2)) begin step(); #1 chk("idle_busy", 32'(busy), 0); end
    end
    chk_mem();

    // Reset in the middle of a stalled dump
    step(); s_valid = 1'b1; s_data = 16'hC003;
    step(); step(); #1 chk("rst_pre_valid", 32'(m_valid), 1);
    rstn = 1'b0; #1;
    chk_reset_outputs("midrst");
    ref_err = 1'b0;
    step(); step(); rstn = 1'b1;
    pay_q = {16'hBEEF, 16'h0BAD};
    do_load(1'b0, 0);
    do_dump(3, 1);
    chk_mem();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/system_loader.md
SYSTEM_LOADER -- requirements
Module: system_loader

Interface
REQ-001 Parameter W_I, 16, IRAM word width.
REQ-002 Parameter W_D, 8, DRAM word width.
REQ-003 Parameter I_DEPTH, 256, IRAM words; AI=$clog2(I_DEPTH).
REQ-004 Parameter D_DEPTH, 256, DRAM words; AD=$clog2(D_DEPTH).
REQ-005 Parameter W_S, 16, stream width; SHALL be >= max(W_I,W_D) and >= 3.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rstn  in  1  reset, asynchronous, active-low.
REQ-008 s_valid/s_ready/s_data  in/out/in  1/1/W_S  command+payload input stream.
REQ-009 m_valid/m_ready/m_data/m_last  out/in/out/out  1/1/W_S/1  response output stream.
REQ-010 iram_write/iram_addr/iram_din  out  1/AI/W_I  IRAM write port.
REQ-011 dram_write/dram_addr/dram_din  out  1/AD/W_D  DRAM port; dram_dout  in  W_D, valid one cycle after address (latency 1).
REQ-012 cpu_start  out  1  one-cycle start pulse; cpu_idle  in  1  CPU finished.
REQ-013 busy  out  1  high whenever state != IDLE; err  out  1  sticky overflow flag.

Function
REQ-014 Transfer on a stream occurs only in a cycle where valid and ready are both 1; m_valid, once high, SHALL hold with m_data/m_last stable until m_ready.
REQ-015 In IDLE, s_ready=1; accepted word is a header: cmd=s_data[W_S-1:W_S-2], L=s_data[W_S-3:0], word count N=L+1.
REQ-016 cmd 00 -> LOAD_I, 01 -> LOAD_D, 10 -> RUN_START, 11 -> DUMP_RD; counter cnt cleared to 0 on header accept.
REQ-017 LOAD_I/LOAD_D: s_ready=1; each accepted word, if cnt < depth, SHALL drive write=1, addr=cnt, din=s_data low bits in that same cycle (combinational).
REQ-018 Load words with cnt >= depth SHALL be accepted, not written, and set err=1; addresses never wrap.
REQ-019 Load states return to IDLE in the cycle after the Nth payload word is accepted; no response word is sent for loads.
REQ-020 s_ready=0 in all states other than IDLE/LOAD_I/LOAD_D.
REQ-021 RUN_START: cpu_start=1 for exactly one cycle, cycle counter cyc cleared, next state RUN_WAIT; L ignored.
REQ-022 RUN_WAIT: cyc increments each cycle, saturating at 2^W_S-1; when cpu_idle=1 is sampled, go to RUN_RESP; cpu_idle in the RUN_START cycle is ignored.
REQ-023 RUN_RESP: m_valid=1, m_data=cyc, m_last=1; on handshake -> IDLE.
REQ-024 DUMP_RD: drive dram_addr=cnt, dram_write=0; next cycle -> DUMP_TX capturing dram_dout.
REQ-025 DUMP_TX: m_valid=1, m_data=captured word zero-extended, m_last=1 iff cnt==N-1 or cnt==D_DEPTH-1; on handshake, cnt++ and -> DUMP_RD, or -> IDLE after last.
REQ-026 Dump N > D_DEPTH SHALL stop at D_DEPTH words with m_last on word D_DEPTH-1 and set err=1.
REQ-027 Throughput: load 1 word/cycle; dump 1 word per 2 cycles minimum.
REQ-028 iram_write, dram_write, cpu_start SHALL be 0 outside the states stated above.

Reset
REQ-029 rstn=0 SHALL immediately force state IDLE, cnt=0, cyc=0, err=0, m_valid=0, m_last=0, cpu_start=0, iram_write=0, dram_write=0, busy=0, m_data=0.
REQ-030 Reset mid-operation SHALL abort without further memory writes; memory contents are not cleared; err is cleared only by reset.
REQ-031 After rstn rises, first accepted s_data word SHALL be treated as a header.

Verification
REQ-032 Header 0x0002 then 3 words 0x1234,0x0001,0x0000 -> IRAM[0..2] written in 3 consecutive cycles, busy low cycle after, no m_valid.
REQ-033 Header 0x4001, words 0x00AA,0x0055 -> DRAM[0]=0xAA, DRAM[1]=0x55; then header 0xC001 -> m_data 0x00AA (m_last=0), 0x0055 (m_last=1).
REQ-034 Header 0x8000, cpu_idle driven low, raised 10 cycles after cpu_start -> single cpu_start pulse, response m_data=10 with m_last=1.
REQ-035 Header 0x4100 (N=257) with D_DEPTH=256 -> 256 writes, 257th accepted without write, err=1 and stays 1.
REQ-036 Dump with m_ready held low 5 cycles -> m_valid/m_data stable throughout; rstn pulsed low mid-dump -> all outputs at reset values same cycle, next word is a header.
